// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and defaults for the spike rate decoder: FSM encoding and
// the default widths used by the top and its bench.
package spike_rate_decoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int WINDOW_W_DEF = 8;
  localparam int COUNT_W_DEF  = 8;

  // All-ones saturation ceiling for a counter of the default width.
  localparam logic [COUNT_W_DEF-1:0] COUNT_MAX_DEF = '1;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result handshake between the decoder (master) and the readout stage (slave).
// rate_valid/rate_out hold steady until the cycle rate_valid & rate_ready are both 1.
interface spike_rate_decoder_if #(
  parameter int COUNT_W = 8
);
  logic [COUNT_W-1:0] rate_out;
  logic               rate_valid;
  logic               rate_ready;
  logic               overrun;

  modport master (
    output rate_out,
    output rate_valid,
    output overrun,
    input  rate_ready
  );

  modport slave (
    input  rate_out,
    input  rate_valid,
    input  overrun,
    output rate_ready
  );
endinterface

// File: rtl/spike_rate_decoder_counter.sv
// Saturating spike counter. next_count is the value the count would take this
// cycle, which the top uses directly as the window result on the last cycle.
module spike_sat_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               start,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] next_count
);
  localparam logic [COUNT_W-1:0] MAX = '1;

  logic [COUNT_W-1:0] base;

  // start restarts the tally from zero so the first sample of a window counts.
  always_comb begin
    base       = start ? '0 : count;
    next_count = (inc && (base != MAX)) ? base + 1'b1 : base;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window and hands each completed count to
// the readout stage; results arriving while one is still unconsumed are dropped.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int WINDOW_W = WINDOW_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                spike_in,
  spike_rate_decoder_if.master rate,
  output state_t              fsm_state
);
  state_t              state;
  logic [WINDOW_W-1:0] cyc;
  logic [WINDOW_W-1:0] last_idx;
  logic [WINDOW_W-1:0] last_idx_new;
  logic [WINDOW_W-1:0] last_idx_cur;
  logic                is_first;
  logic                last;
  logic                new_result;
  logic [COUNT_W-1:0]  cnt;
  logic [COUNT_W-1:0]  cnt_next;
  logic [COUNT_W-1:0]  out_q;
  logic                valid_q;
  logic                ovr_q;

  // Window cycle 0 is either the first enabled cycle out of IDLE or the
  // cycle right after a completed window (cyc parked at 0).
  always_comb begin
    is_first     = (state == ST_IDLE) || (cyc == '0);
    last_idx_new = (window_len == '0) ? '0 : window_len - 1'b1;
    last_idx_cur = is_first ? last_idx_new : last_idx;
    last         = (cyc == last_idx_cur);
    new_result   = enable && last;
  end

  spike_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (!enable),
    .start      (is_first),
    .inc        (spike_in),
    .count      (cnt),
    .next_count (cnt_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      last_idx <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      cyc   <= '0;
    end else begin
      state <= ST_COUNT;
      cyc   <= last ? '0 : cyc + 1'b1;
      if (is_first) begin
        last_idx <= last_idx_new;
      end
    end
  end

  // A pending result is only replaced in the same cycle it is being consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (new_result) begin
        if (!valid_q || rate.rate_ready) begin
          out_q   <= cnt_next;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rate.rate_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rate.rate_out   = out_q;
  assign rate.rate_valid = valid_q;
  assign rate.overrun    = ovr_q;
  assign fsm_state       = state;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (8-bit and 4-bit counts) share
// stimulus and are compared each cycle against a window-level reference model.
module tb_spike_rate_decoder;
  import spike_rate_decoder_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] window_len;
  logic       spike_in;
  logic       ready;
  state_t     st8;
  state_t     st4;

  int tests;
  int fails;

  // Reference model state
  int         m_active;
  int         m_len;
  int         win_q[$];
  logic       m_valid;
  logic       m_ovr;
  logic [7:0] m_out8;
  logic [3:0] m_out4;
  logic [7:0] exp_q[$];

  spike_rate_decoder_if #(.COUNT_W(8)) if8 ();
  spike_rate_decoder_if #(.COUNT_W(4)) if4 ();

  assign if8.rate_ready = ready;
  assign if4.rate_ready = ready;

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .window_len (window_len),
    .spike_in   (spike_in),
    .rate       (if8.master),
    .fsm_state  (st8)
  );

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .window_len (window_len),
    .spike_in   (spike_in),
    .rate       (if4.master),
    .fsm_state  (st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_len    = 0;
    win_q.delete();
    exp_q.delete();
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_out8   = '0;
    m_out4   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid8"}, {31'd0, if8.rate_valid}, {31'd0, m_valid});
    check({tag, "_out8"},   {24'd0, if8.rate_out},   {24'd0, m_out8});
    check({tag, "_ovr8"},   {31'd0, if8.overrun},    {31'd0, m_ovr});
    check({tag, "_valid4"}, {31'd0, if4.rate_valid}, {31'd0, m_valid});
    check({tag, "_out4"},   {28'd0, if4.rate_out},   {28'd0, m_out4});
    check({tag, "_ovr4"},   {31'd0, if4.overrun},    {31'd0, m_ovr});
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic en, input logic [7:0] wl, input logic sp, input logic rdy,
                      input string tag);
    int   sum;
    logic res;
    logic nov;
    enable     = en;
    window_len = wl;
    spike_in   = sp;
    ready      = rdy;
    if (if8.rate_valid && rdy) begin
      if (exp_q.size() == 0) check({tag, "_sb_extra"}, 32'd1, 32'd0);
      else check({tag, "_sb_rate"}, {24'd0, if8.rate_out}, {24'd0, exp_q.pop_front()});
    end
    res = 1'b0;
    sum = 0;
    nov = 1'b0;
    if (!en) begin
      m_active = 0;
      win_q.delete();
    end else begin
      if (m_active == 0) begin
        m_active = 1;
        m_len    = (wl == 0) ? 1 : int'(wl);
        win_q.delete();
      end
      win_q.push_back(int'(sp));
      if (win_q.size() == m_len) begin
        foreach (win_q[k]) sum += win_q[k];
        res      = 1'b1;
        m_active = 0;
      end
    end
    if (res) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_out8  = (sum > 255) ? 8'd255 : 8'(sum);
        m_out4  = (sum > 15) ? 4'd15 : 4'(sum);
        exp_q.push_back(m_out8);
      end else begin
        nov = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovr = nov;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    enable     = 1'b0;
    window_len = 8'd0;
    spike_in   = 1'b0;
    ready      = 1'b0;
    reset_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_state", {31'd0, st8}, {31'd0, ST_IDLE});
    reset_n = 1'b1;

    // 1: async reset while a result is pending
    for (int i = 0; i < 5; i++) step(1'b1, 8'd2, 1'b1, 1'b0, "pre_rst");
    check("pre_rst_pending", {31'd0, if8.rate_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b0, 8'd2, 1'b1, 1'b1, "post_rst");
    check("post_rst_state", {31'd0, st8}, {31'd0, ST_IDLE});

    // 2: window 10, spike every other cycle
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 8'd10, (i % 2 == 0), 1'b1, "alt10");
      if (i == 9) begin
        check("alt10_rate", {24'd0, if8.rate_out}, 32'd5);
        check("alt10_valid", {31'd0, if8.rate_valid}, 32'd1);
      end
      if (i == 10) check("alt10_valid_drop", {31'd0, if8.rate_valid}, 32'd0);
    end

    // 3: saturation of the 4-bit instance
    step(1'b0, 8'd20, 1'b0, 1'b1, "idle");
    for (int i = 0; i < 20; i++) step(1'b1, 8'd20, 1'b1, 1'b1, "sat20");
    check("sat20_out4", {28'd0, if4.rate_out}, 32'd15);
    check("sat20_out8", {24'd0, if8.rate_out}, 32'd20);

    // 4: overrun while result is not consumed
    step(1'b0, 8'd4, 1'b0, 1'b1, "idle");
    step(1'b0, 8'd4, 1'b0, 1'b1, "idle");
    for (int i = 0; i < 4; i++) step(1'b1, 8'd4, (i < 2), 1'b0, "ovr_w1");
    for (int i = 0; i < 4; i++) step(1'b1, 8'd4, (i < 3), 1'b0, "ovr_w2");
    check("ovr_pulse", {31'd0, if8.overrun}, 32'd1);
    check("ovr_held", {24'd0, if8.rate_out}, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd4, (i == 0), (i == 3), "ovr_w3");
    check("ovr_w3_rate", {24'd0, if8.rate_out}, 32'd1);
    check("ovr_w3_noovr", {31'd0, if8.overrun}, 32'd0);

    // 5: abort mid-window, then a fresh window
    step(1'b0, 8'd10, 1'b0, 1'b1, "idle");
    for (int i = 0; i < 4; i++) step(1'b1, 8'd10, 1'b1, 1'b1, "abort");
    step(1'b0, 8'd10, 1'b1, 1'b1, "abort_drop");
    for (int i = 0; i < 10; i++) step(1'b1, 8'd10, (i == 0), 1'b1, "fresh");
    check("fresh_rate", {24'd0, if8.rate_out}, 32'd1);

    // 6: window_len 0 behaves as one cycle
    step(1'b0, 8'd0, 1'b0, 1'b1, "idle");
    step(1'b1, 8'd0, 1'b1, 1'b1, "len0_a");
    check("len0_a_rate", {24'd0, if8.rate_out}, 32'd1);
    step(1'b1, 8'd0, 1'b0, 1'b1, "len0_b");
    check("len0_b_rate", {24'd0, if8.rate_out}, 32'd0);
    step(1'b1, 8'd0, 1'b1, 1'b1, "len0_c");
    check("len0_c_valid", {31'd0, if8.rate_valid}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) != 0),
           8'($urandom_range(0, (i < 300) ? 6 : 24)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0),
           "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
